decoding_block: RTL
===================

Name: decoding_block

Overview:
Receive-side counterpart of the lane encoder. It accepts deserialized 66-bit (Gen3, 64b/66b) or 132-bit (Gen4, 128b/132b) symbols for two lanes, checks and strips the sync header, and replays the payload as one byte per lane per cycle, flagging ordered-set symbols. It sits between the lane deserializers and the receive transaction/ordered-set logic. Gen2 (gen_speed=0) is byte pass-through.

Parameters:
BAD_HDR_LIMIT, 4, consecutive invalid-header symbols (1..7) before lock_lost asserts.

Ports:
dec_clk  in  1  decoder clock
rst  in  1  asynchronous, active-high reset
enable  in  1  block enable; low = synchronous clear of all state and outputs
gen_speed  in  2  2 = 64b/66b, 1 = 128b/132b, 0 = byte pass-through, 3 = reserved
sym_valid  in  1  one-cycle strobe: new symbol present on both lane inputs
lane_0_rx_enc  in  132  lane 0 symbol (66-bit mode uses [65:0])
lane_1_rx_enc  in  132  lane 1 symbol
lane_0_rx  out  8  lane 0 decoded byte
lane_1_rx  out  8  lane 1 decoded byte
rx_valid  out  1  byte outputs valid this cycle
rx_os  out  1  current byte belongs to an ordered-set symbol
byte_idx  out  4  index of current byte within its symbol
sync_err  out  1  one-cycle pulse per rejected symbol
overflow  out  1  sticky; a symbol was dropped for lack of buffer space
lock_lost  out  1  sticky; BAD_HDR_LIMIT consecutive bad headers

Behaviour:
- Reset (rst=1, async) or enable=0 (sync): all outputs 0, both buffers empty, FSM IDLE, error counter 0.
- Header decode, gen_speed=2: [1:0]=01 data, 10 ordered set; payload [65:2]; byte k = [9+8k:2+8k], k=0..7.
- gen_speed=1: [131:128]=1010 data, 0101 ordered set; payload [127:0]; byte k = [7+8k:8k], k=0..15.
- A symbol is rejected if either lane header is illegal or the lanes disagree on type. A rejected symbol enters no buffer, pulses sync_err the next cycle, and increments the consecutive-bad counter. Any accepted symbol clears the counter. lock_lost sets when the counter reaches BAD_HDR_LIMIT and stays set until reset or enable=0.
- Buffering: active register (being unloaded) plus one pending register, each holding both lanes' payload and the OS flag.
- FSM states:
  - IDLE: accepted sym_valid loads active; go to UNLOAD.
  - UNLOAD: each cycle emits byte byte_idx with rx_valid=1 and rx_os=active OS flag; byte_idx increments.
  - At the last byte (7 or 15): if pending is full, move it to active and stay in UNLOAD with byte_idx=0. Else, if an accepted sym_valid arrives this cycle, load it into active. Else go to IDLE.
- Latency: accepted sym_valid at cycle t gives byte 0 at t+1. A symbol every 8 (Gen3) or 16 (Gen4) cycles produces a gap-free stream.
- Accepted sym_valid in UNLOAD, not at the last byte: written to pending if empty. If pending is full, the symbol is dropped and overflow sets.
- Simultaneous case at the last byte with pending full and a new accepted symbol: pending goes to active, new symbol goes to pending.
- When not emitting: rx_valid=0, rx_os=0, lane_x_rx hold their last value, byte_idx=0.
- gen_speed=0: lane_x_rx <= lane_x_rx_enc[7:0] and rx_valid <= sym_valid each cycle. No header check; rx_os=0, byte_idx=0.
- gen_speed=3: behaves as enable=0.
- Any gen_speed change while enabled: flush both buffers, go to IDLE, rx_valid=0 the next cycle. Sticky flags are kept.

Optional Feature:
DEC_ERR_CNT_EN: when defined, adds output err_cnt[15:0]. It is a saturating count of rejected symbols plus dropped symbols (both in one cycle counts 2), cleared by reset or enable=0. Undefined: the port and counter are absent and all other behaviour is identical.

Test Plan:
- Gen3: lane_0 symbol {64'h0807060504030201,2'b01} at t → bytes 01..08 at t+1..t+8 with rx_valid=1, rx_os=0, byte_idx 0..7.
- Gen4: header 0101, payload 128'h0F0E..0100 on both lanes → 16 bytes 00..0F, rx_os=1 throughout; next symbol strobed at the last byte gives byte_idx 15→0 with no gap.
- Bad headers: Gen3 header 2'b00 → sync_err pulse, no rx_valid. Lanes 01/10 mismatch → sync_err. With BAD_HDR_LIMIT=4, 4 consecutive bad symbols → lock_lost=1; a later good symbol decodes but lock_lost stays 1.
- Overflow: Gen3 sym_valid at t, t+2, t+4 → first two symbols decoded back-to-back, third dropped, overflow=1.
- Gen2 pass-through: sym_valid with lane_0_rx_enc[7:0]=8'hA5 → lane_0_rx=A5, rx_valid=1 next cycle.
- rst=1 mid-UNLOAD at byte 3 → all outputs 0 immediately. After release, a new symbol decodes from byte 0. With DEC_ERR_CNT_EN, err_cnt=0.

Source files
------------

// File: rtl/decoding_block.sv
// Two-lane receive decoder: strips 64b/66b or 128b/132b sync headers and replays payload bytewise.
// Optional DEC_ERR_CNT_EN adds err_cnt, a saturating count of rejected plus dropped symbols.
module decoding_block #(
  parameter int BAD_HDR_LIMIT = 4
) (
  input  logic         dec_clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [1:0]   gen_speed,
  input  logic         sym_valid,
  input  logic [131:0] lane_0_rx_enc,
  input  logic [131:0] lane_1_rx_enc,
  output logic [7:0]   lane_0_rx,
  output logic [7:0]   lane_1_rx,
  output logic         rx_valid,
  output logic         rx_os,
  output logic [3:0]   byte_idx,
  output logic         sync_err,
  output logic         overflow,
  output logic         lock_lost
`ifdef DEC_ERR_CNT_EN
  ,
  output logic [15:0]  err_cnt
`endif
);

  typedef enum logic {IDLE, UNLOAD} state_t;

  state_t       state;
  logic [1:0]   prev_gen;
  logic [2:0]   bad_cnt;
  logic         pend_full;
  logic [127:0] act_0, act_1, pend_0, pend_1;
  logic         act_os, pend_os;
  logic [1:0]   hdr_0, hdr_1;
  logic [127:0] pay_0, pay_1;
  logic         coded, gen_chg, acc, rej, at_last;
  logic         ld_act_new, ld_act_pend, ld_pend_new, drop;
  logic [3:0]   nxt_idx;

  // Returns {legal, is_ordered_set} for one lane's header.
  function automatic logic [1:0] hdr_class(input logic [1:0] gen, input logic [131:0] s);
    logic [1:0] c;
    c = 2'b00;
    if (gen == 2'd2) begin
      if (s[1:0] == 2'b01)      c = 2'b10;
      else if (s[1:0] == 2'b10) c = 2'b11;
    end else begin
      if (s[131:128] == 4'b1010)      c = 2'b10;
      else if (s[131:128] == 4'b0101) c = 2'b11;
    end
    return c;
  endfunction

  function automatic logic [127:0] strip_hdr(input logic [1:0] gen, input logic [131:0] s);
    return (gen == 2'd2) ? {64'd0, s[65:2]} : s[127:0];
  endfunction

  function automatic logic [7:0] pick_byte(input logic [127:0] p, input logic [3:0] k);
    return p[{k, 3'b000} +: 8];
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    hdr_0       = hdr_class(gen_speed, lane_0_rx_enc);
    hdr_1       = hdr_class(gen_speed, lane_1_rx_enc);
    pay_0       = strip_hdr(gen_speed, lane_0_rx_enc);
    pay_1       = strip_hdr(gen_speed, lane_1_rx_enc);
    coded       = enable && (gen_speed == 2'd1 || gen_speed == 2'd2);
    gen_chg     = gen_speed != prev_gen;
    acc         = coded && !gen_chg && sym_valid && hdr_0[1] && hdr_1[1] && (hdr_0[0] == hdr_1[0]);
    rej         = coded && !gen_chg && sym_valid && !acc;
    at_last     = coded && !gen_chg && (state == UNLOAD) &&
                  (byte_idx == ((gen_speed == 2'd2) ? 4'd7 : 4'd15));
    ld_act_pend = at_last && pend_full;
    ld_act_new  = acc && ((state == IDLE) || (at_last && !pend_full));
    ld_pend_new = acc && (((state == UNLOAD) && !at_last && !pend_full) || ld_act_pend);
    drop        = acc && (state == UNLOAD) && !at_last && pend_full;
    nxt_idx     = byte_idx + 4'd1;
  end

  // Payload storage: validity lives in state/pend_full, so no reset needed here.
  always_ff @(posedge dec_clk) begin
    if (ld_act_new) begin
      act_0  <= pay_0;
      act_1  <= pay_1;
      act_os <= hdr_0[0];
    end else if (ld_act_pend) begin
      act_0  <= pend_0;
      act_1  <= pend_1;
      act_os <= pend_os;
    end
    if (ld_pend_new) begin
      pend_0  <= pay_0;
      pend_1  <= pay_1;
      pend_os <= hdr_0[0];
    end
  end

  always_ff @(posedge dec_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prev_gen  <= 2'd0;
      bad_cnt   <= '0;
      pend_full <= 1'b0;
      lane_0_rx <= '0;
      lane_1_rx <= '0;
      rx_valid  <= 1'b0;
      rx_os     <= 1'b0;
      byte_idx  <= '0;
      sync_err  <= 1'b0;
      overflow  <= 1'b0;
      lock_lost <= 1'b0;
`ifdef DEC_ERR_CNT_EN
      err_cnt   <= '0;
`endif
    end else if (!enable || gen_speed == 2'd3) begin
      state     <= IDLE;
      prev_gen  <= gen_speed;
      bad_cnt   <= '0;
      pend_full <= 1'b0;
      lane_0_rx <= '0;
      lane_1_rx <= '0;
      rx_valid  <= 1'b0;
      rx_os     <= 1'b0;
      byte_idx  <= '0;
      sync_err  <= 1'b0;
      overflow  <= 1'b0;
      lock_lost <= 1'b0;
`ifdef DEC_ERR_CNT_EN
      err_cnt   <= '0;
`endif
    end else begin
      prev_gen <= gen_speed;
      sync_err <= rej;
      if (rej) begin
        if (bad_cnt < 3'(BAD_HDR_LIMIT)) bad_cnt <= bad_cnt + 3'd1;
        if (int'(bad_cnt) + 1 >= BAD_HDR_LIMIT) lock_lost <= 1'b1;
      end else if (acc) begin
        bad_cnt <= '0;
      end
      if (drop) overflow <= 1'b1;
`ifdef DEC_ERR_CNT_EN
      err_cnt <= sat_add(err_cnt, {1'b0, rej} + {1'b0, drop});
`endif
      if (gen_chg) begin
        state     <= IDLE;
        pend_full <= 1'b0;
        rx_valid  <= 1'b0;
        rx_os     <= 1'b0;
        byte_idx  <= '0;
      end else if (gen_speed == 2'd0) begin
        state     <= IDLE;
        pend_full <= 1'b0;
        lane_0_rx <= lane_0_rx_enc[7:0];
        lane_1_rx <= lane_1_rx_enc[7:0];
        rx_valid  <= sym_valid;
        rx_os     <= 1'b0;
        byte_idx  <= '0;
      end else begin
        if (ld_pend_new)      pend_full <= 1'b1;
        else if (ld_act_pend) pend_full <= 1'b0;
        // Byte 0 of a newly active symbol is emitted on the same edge it is loaded.
        if (ld_act_new) begin
          state     <= UNLOAD;
          rx_valid  <= 1'b1;
          rx_os     <= hdr_0[0];
          byte_idx  <= '0;
          lane_0_rx <= pay_0[7:0];
          lane_1_rx <= pay_1[7:0];
        end else if (ld_act_pend) begin
          state     <= UNLOAD;
          rx_valid  <= 1'b1;
          rx_os     <= pend_os;
          byte_idx  <= '0;
          lane_0_rx <= pend_0[7:0];
          lane_1_rx <= pend_1[7:0];
        end else if (state == UNLOAD && !at_last) begin
          rx_valid  <= 1'b1;
          rx_os     <= act_os;
          byte_idx  <= nxt_idx;
          lane_0_rx <= pick_byte(act_0, nxt_idx);
          lane_1_rx <= pick_byte(act_1, nxt_idx);
        end else begin
          state    <= IDLE;
          rx_valid <= 1'b0;
          rx_os    <= 1'b0;
          byte_idx <= '0;
        end
      end
    end
  end

endmodule
